// File: rtl/divisor_restoring_param_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
package divisor_restoring_param_pkg;

  // Controller states: waiting for a request, iterating, applying signs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Number of bits needed to hold values 0 .. value-1 (never less than 1).
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/divisor_restoring_param_if.sv
// Start/done handshake and operand/result bus of the restoring divider.
interface divisor_restoring_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             busy;
  logic             div0;

  // Requester side: issues operands, observes results.
  modport master (
    output start, sgn, A_in, B_in,
    input  Q, R, done, busy, div0
  );

  // Divider side: consumes operands, produces results.
  modport slave (
    input  start, sgn, A_in, B_in,
    output Q, R, done, busy, div0
  );
endinterface

// File: rtl/divisor_restoring_param_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference if non-negative, otherwise restore.
module divisor_restoring_param_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // structurally zero; the shifted value still needs WIDTH+1 bits.
  assign unused_rem_msb = rem_in[WIDTH];

  assign shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};

  // shifted < 2*divisor, so the WIDTH+1-bit two's-complement difference cannot
  // overflow and its MSB is the sign of the trial.
  assign trial   = shifted - {1'b0, divisor};

  assign rem_out = trial[WIDTH] ? shifted : trial;
  assign quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/divisor_restoring_param.sv
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// signed mode and divide-by-zero reporting.
module divisor_restoring_param
  import divisor_restoring_param_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  divisor_restoring_param_if.slave     bus
);
  localparam int CNT_W = clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   r_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               div0_reg;

  logic               signed_mode;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag_in;
  logic               b_is_zero;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Operand sign decode and magnitudes; the most negative value maps onto its
  // own bit pattern, which is the correct unsigned magnitude.
  assign signed_mode = (SIGNED_EN != 0) && bus.sgn;
  assign a_neg       = signed_mode && bus.A_in[WIDTH-1];
  assign b_neg       = signed_mode && bus.B_in[WIDTH-1];
  assign a_mag       = a_neg ? ({WIDTH{1'b0}} - bus.A_in) : bus.A_in;
  assign b_mag_in    = b_neg ? ({WIDTH{1'b0}} - bus.B_in) : bus.B_in;
  assign b_is_zero   = (bus.B_in == {WIDTH{1'b0}});

  divisor_restoring_param_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (b_mag),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Sign fix-up: quotient negative when operand signs differ, remainder
  // follows the dividend; MIN/-1 wraps back to MIN naturally.
  assign q_fix = neg_q ? ({WIDTH{1'b0}} - quo) : quo;
  assign r_fix = neg_r ? ({WIDTH{1'b0}} - rem[WIDTH-1:0]) : rem[WIDTH-1:0];

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.done = done_reg;
  assign bus.busy = busy_reg;
  assign bus.div0 = div0_reg;

  // Controller: accept, iterate WIDTH times, then fix signs and publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      rem      <= {(WIDTH+1){1'b0}};
      quo      <= {WIDTH{1'b0}};
      b_mag    <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      q_reg    <= {WIDTH{1'b0}};
      r_reg    <= {WIDTH{1'b0}};
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      div0_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
            cnt      <= {CNT_W{1'b0}};
            rem      <= {(WIDTH+1){1'b0}};
            b_mag    <= b_mag_in;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            if (b_is_zero) begin
              // Raw dividend parked in quo; it becomes R one edge later.
              zero_div <= 1'b1;
              quo      <= bus.A_in;
              state    <= FIX;
            end else begin
              zero_div <= 1'b0;
              quo      <= a_mag;
              busy_reg <= 1'b1;
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            state <= FIX;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (zero_div) begin
            q_reg    <= {WIDTH{1'b1}};
            r_reg    <= quo;
            div0_reg <= 1'b1;
          end else begin
            q_reg    <= q_fix;
            r_reg    <= r_fix;
            div0_reg <= 1'b0;
          end
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule
